// File: rtl/kb_hex_entry_if.sv
// Keyboard event inputs, committed-value outputs and display scan outputs of kb_hex_entry.
// master = keyboard side / observer, slave = the entry unit.
interface kb_hex_entry_if #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS + 1)
);
  logic                  key_valid;
  logic [8:0]            key_code;
  logic                  key_make;
  logic [4*DIGITS-1:0]   value;
  logic                  value_valid;
  logic                  err;
  logic [CW-1:0]         count;
  logic [DIGITS-1:0]     ssd_ctl;
  logic [3:0]            scan_bcd;
  logic                  scan_blank;

  modport master (
    output key_valid, key_code, key_make,
    input  value, value_valid, err, count, ssd_ctl, scan_bcd, scan_blank
  );

  modport slave (
    input  key_valid, key_code, key_make,
    output value, value_valid, err, count, ssd_ctl, scan_bcd, scan_blank
  );
endinterface

// File: rtl/kb_hex_entry.sv
// PS/2 make events -> hex entry buffer with edit keys, plus a time-multiplexed display scan.
// Events take effect on the next edge; no backpressure, one event per cycle is always accepted.
module kb_hex_entry #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CW          = $clog2(DIGITS + 1)
) (
  input logic          clk,
  input logic          rst,
  kb_hex_entry_if.slave kb
);
  localparam int BW = 4 * DIGITS;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(DIGITS);
  localparam logic [CW-1:0] FULL     = CW'(DIGITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(DIGITS - 1);

  logic [BW-1:0] buf_r;
  logic [CW-1:0] count_r;
  logic [BW-1:0] value_r;
  logic          value_valid_r;
  logic          err_r;
  logic          held;
  logic [7:0]    held_code;
  logic [DW-1:0] div_r;
  logic [SW-1:0] scan_idx;

  logic       is_hex;
  logic [3:0] hex_val;
  logic       accept;
  logic       brk_hit;

  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'h0;
    case (kb.key_code[7:0])
      8'h45: hex_val = 4'h0;
      8'h16: hex_val = 4'h1;
      8'h1E: hex_val = 4'h2;
      8'h26: hex_val = 4'h3;
      8'h25: hex_val = 4'h4;
      8'h2E: hex_val = 4'h5;
      8'h36: hex_val = 4'h6;
      8'h3D: hex_val = 4'h7;
      8'h3E: hex_val = 4'h8;
      8'h46: hex_val = 4'h9;
      8'h1C: hex_val = 4'hA;
      8'h32: hex_val = 4'hB;
      8'h21: hex_val = 4'hC;
      8'h23: hex_val = 4'hD;
      8'h24: hex_val = 4'hE;
      8'h2B: hex_val = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

  // Typematic repeats arrive as makes of the code already held down.
  assign accept  = kb.key_valid && kb.key_make && !kb.key_code[8] &&
                   !(held && (kb.key_code[7:0] == held_code));
  assign brk_hit = kb.key_valid && !kb.key_make && (kb.key_code == {1'b0, held_code});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_r         <= '0;
      count_r       <= '0;
      value_r       <= '0;
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      held          <= 1'b0;
      held_code     <= 8'h00;
    end else begin
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      if (brk_hit) begin
        held <= 1'b0;
      end
      if (accept) begin
        held      <= 1'b1;
        held_code <= kb.key_code[7:0];
        if (is_hex) begin
          if (count_r < FULL) begin
            buf_r   <= {buf_r[BW-5:0], hex_val};
            count_r <= count_r + CW'(1);
          end else begin
            err_r <= 1'b1;
          end
        end else begin
          case (kb.key_code[7:0])
            8'h66: begin
              if (count_r != '0) begin
                buf_r   <= {4'h0, buf_r[BW-1:4]};
                count_r <= count_r - CW'(1);
              end else begin
                err_r <= 1'b1;
              end
            end
            8'h76: begin
              buf_r   <= '0;
              count_r <= '0;
            end
            8'h5A: begin
              if (count_r != '0) begin
                value_r       <= buf_r;
                value_valid_r <= 1'b1;
                buf_r         <= '0;
                count_r       <= '0;
              end else begin
                err_r <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r    <= '0;
      scan_idx <= '0;
    end else if (div_r == DIV_LAST) begin
      div_r    <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + SW'(1);
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  assign kb.value       = value_r;
  assign kb.value_valid = value_valid_r;
  assign kb.err         = err_r;
  assign kb.count       = count_r;
  assign kb.ssd_ctl     = ~(DIGITS'(1) << scan_idx);
  assign kb.scan_bcd    = buf_r[{scan_idx, 2'b00} +: 4];
  // Digit 0 stays lit so an empty buffer reads "0".
  assign kb.scan_blank  = (scan_idx != '0) && (32'(scan_idx) >= 32'(count_r));
endmodule

// File: tb/tb_kb_hex_entry.sv
module tb_kb_hex_entry;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  kb_hex_entry_if #(.DIGITS(4)) kb ();
  kb_hex_entry #(.DIGITS(4), .REFRESH_DIV(4)) dut (.clk(clk), .rst(rst), .kb(kb));

  always #5 clk = ~clk;

  // value_valid and err must never coincide
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (kb.value_valid && kb.err) begin
        fails++;
        $display("FAIL vv_err_exclusive: value_valid=%b err=%b, required not both 1", kb.value_valid, kb.err);
      end
    end
  end

  task automatic send(input logic [8:0] code, input logic make);
    kb.key_valid = 1'b1;
    kb.key_code  = code;
    kb.key_make  = make;
    @(negedge clk);
    kb.key_valid = 1'b0;
    kb.key_make  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (kb.count !== 3'd0 || kb.value !== 16'h0 || kb.value_valid !== 1'b0 || kb.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: count=%0d value=%h vv=%b err=%b, required 0 0000 0 0", kb.count, kb.value, kb.value_valid, kb.err);
    end
    checks++;
    if (kb.ssd_ctl !== 4'hE || kb.scan_bcd !== 4'h0 || kb.scan_blank !== 1'b0) begin
      fails++;
      $display("FAIL reset_disp: ssd_ctl=%h bcd=%h blank=%b, required e 0 0", kb.ssd_ctl, kb.scan_bcd, kb.scan_blank);
    end
    rst = 1'b1;
  endtask

  task automatic test_commit;
    int vv = 0;
    send(9'h016, 1'b1); vv += int'(kb.value_valid);
    send(9'h016, 1'b0); vv += int'(kb.value_valid);
    send(9'h01C, 1'b1); vv += int'(kb.value_valid);
    send(9'h01C, 1'b0); vv += int'(kb.value_valid);
    send(9'h05A, 1'b1); vv += int'(kb.value_valid);
    checks++;
    if (kb.value_valid !== 1'b1 || kb.value !== 16'h001A || kb.count !== 3'd0) begin
      fails++;
      $display("FAIL commit: vv=%b value=%h count=%0d, required 1 001a 0", kb.value_valid, kb.value, kb.count);
    end
    @(negedge clk);
    vv += int'(kb.value_valid);
    checks++;
    if (vv != 1) begin
      fails++;
      $display("FAIL commit_pulse: value_valid cycles=%0d, required 1", vv);
    end
    send(9'h05A, 1'b0);
  endtask

  task automatic test_repeat;
    int errs = 0;
    for (int i = 0; i < 3; i++) begin
      send(9'h026, 1'b1);
      errs += int'(kb.err);
    end
    send(9'h026, 1'b0);
    checks++;
    if (kb.count !== 3'd1 || dut.buf_r !== 16'h0003 || errs != 0) begin
      fails++;
      $display("FAIL repeat: count=%0d buf=%h errs=%0d, required 1 0003 0", kb.count, dut.buf_r, errs);
    end
    // Extended make of a digit code is not a key press
    send(9'h116, 1'b1);
    checks++;
    if (kb.count !== 3'd1) begin
      fails++;
      $display("FAIL extended_ignored: count=%0d, required 1", kb.count);
    end
    send(9'h076, 1'b1);
    checks++;
    if (kb.count !== 3'd0 || kb.err !== 1'b0 || kb.value_valid !== 1'b0) begin
      fails++;
      $display("FAIL escape: count=%0d err=%b vv=%b, required 0 0 0", kb.count, kb.err, kb.value_valid);
    end
  endtask

  task automatic test_back_to_back;
    // keys on consecutive cycles, no idle between events
    send(9'h016, 1'b1);
    send(9'h01E, 1'b1);
    send(9'h026, 1'b1);
    send(9'h025, 1'b1);
    checks++;
    if (kb.err !== 1'b0 || kb.count !== 3'd4) begin
      fails++;
      $display("FAIL fill: err=%b count=%0d, required 0 4", kb.err, kb.count);
    end
    send(9'h02E, 1'b1);
    checks++;
    if (kb.err !== 1'b1 || kb.count !== 3'd4 || dut.buf_r !== 16'h1234) begin
      fails++;
      $display("FAIL overflow: err=%b count=%0d buf=%h, required 1 4 1234", kb.err, kb.count, dut.buf_r);
    end
    send(9'h066, 1'b1);
    send(9'h066, 1'b0);
    send(9'h066, 1'b1);
    checks++;
    if (dut.buf_r !== 16'h0012 || kb.count !== 3'd2 || kb.err !== 1'b0) begin
      fails++;
      $display("FAIL backspace: buf=%h count=%0d err=%b, required 0012 2 0", dut.buf_r, kb.count, kb.err);
    end
    send(9'h066, 1'b0);
  endtask

  task automatic test_empty_edits;
    send(9'h076, 1'b1);
    send(9'h05A, 1'b1);
    checks++;
    if (kb.err !== 1'b1 || kb.value_valid !== 1'b0 || kb.value !== 16'h001A) begin
      fails++;
      $display("FAIL empty_enter: err=%b vv=%b value=%h, required 1 0 001a", kb.err, kb.value_valid, kb.value);
    end
    send(9'h066, 1'b1);
    checks++;
    if (kb.err !== 1'b1 || kb.value_valid !== 1'b0 || kb.count !== 3'd0) begin
      fails++;
      $display("FAIL empty_bksp: err=%b vv=%b count=%0d, required 1 0 0", kb.err, kb.value_valid, kb.count);
    end
    @(negedge clk);
    checks++;
    if (kb.err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: err=%b, required 0", kb.err);
    end
    send(9'h066, 1'b0);
  endtask

  task automatic test_scan;
    logic [3:0] pat [4];
    logic [3:0] prev;
    int k = -1;
    int n = 0;
    int idx;
    pat[0] = 4'hE; pat[1] = 4'hD; pat[2] = 4'hB; pat[3] = 4'h7;
    send(9'h03D, 1'b1);
    send(9'h03D, 1'b0);
    prev = kb.ssd_ctl;
    while (n < 10 && kb.ssd_ctl === prev) begin
      @(negedge clk);
      n++;
    end
    for (int j = 0; j < 4; j++) if (kb.ssd_ctl === pat[j]) k = j;
    checks++;
    if (k < 0) begin
      fails++;
      $display("FAIL scan_sync: ssd_ctl=%h after %0d cycles, required a step within 10", kb.ssd_ctl, n);
    end else begin
      for (int i = 0; i < 16; i++) begin
        idx = (k + i / 4) % 4;
        checks++;
        if (kb.ssd_ctl !== pat[idx] || kb.scan_blank !== (idx != 0)) begin
          fails++;
          $display("FAIL scan_step%0d: ssd_ctl=%h blank=%b, required %h %b", i, kb.ssd_ctl, kb.scan_blank, pat[idx], idx != 0);
        end
        if (idx == 0) begin
          checks++;
          if (kb.scan_bcd !== 4'h7) begin
            fails++;
            $display("FAIL scan_bcd%0d: bcd=%h, required 7", i, kb.scan_bcd);
          end
        end
        @(negedge clk);
      end
    end
    send(9'h076, 1'b1);
    send(9'h076, 1'b0);
  endtask

  task automatic test_mid_reset;
    send(9'h016, 1'b1);
    send(9'h01E, 1'b1);
    checks++;
    if (dut.buf_r !== 16'h0012 || kb.count !== 3'd2) begin
      fails++;
      $display("FAIL pre_reset: buf=%h count=%0d, required 0012 2", dut.buf_r, kb.count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (kb.count !== 3'd0 || kb.value !== 16'h0 || kb.value_valid !== 1'b0 || kb.err !== 1'b0 ||
        kb.ssd_ctl !== 4'hE || kb.scan_bcd !== 4'h0 || kb.scan_blank !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d value=%h vv=%b err=%b ssd=%h bcd=%h blank=%b, required 0 0000 0 0 e 0 0",
               kb.count, kb.value, kb.value_valid, kb.err, kb.ssd_ctl, kb.scan_bcd, kb.scan_blank);
    end
    @(negedge clk);
    rst = 1'b1;
    send(9'h016, 1'b1);
    checks++;
    if (kb.count !== 3'd1 || kb.err !== 1'b0 || kb.ssd_ctl !== 4'hE || kb.scan_bcd !== 4'h1) begin
      fails++;
      $display("FAIL post_reset_key: count=%0d err=%b ssd=%h bcd=%h, required 1 0 e 1", kb.count, kb.err, kb.ssd_ctl, kb.scan_bcd);
    end
  endtask

  initial begin
    kb.key_valid = 1'b0;
    kb.key_code  = 9'h000;
    kb.key_make  = 1'b0;
    test_reset;
    @(negedge clk);
    test_commit;
    test_repeat;
    test_back_to_back;
    test_empty_edits;
    test_scan;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
